// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants: FSM states, CPOL/CPHA modes, counter width helpers
package spi_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam bit CPOL_IDLE_LOW  = 1'b0;
    localparam bit CPOL_IDLE_HIGH = 1'b1;
    localparam bit CPHA_LEADING   = 1'b0;
    localparam bit CPHA_TRAILING  = 1'b1;

    // Index width for n requesters; never zero so a 1-bit port still exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counts scl edges 0..2*dw.
    function automatic int bit_cnt_w(input int dw);
        return $clog2(2 * dw + 1);
    endfunction

    // Divider reload value is div-1; width covers up to div.
    function automatic int div_cnt_w(input int div);
        return (div > 1) ? $clog2(div + 1) : 1;
    endfunction

endpackage

// File: rtl/spi_master_arb_if.sv
// rtl/spi_master_arb_if.sv - client request/response and SPI pin bundle for spi_master_arb
interface spi_master_arb_if #(
    parameter int NREQ = 2,
    parameter int DW   = 8,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               done;
    logic [IDW-1:0]     done_id;
    logic [DW-1:0]      rdata;
    logic               scl;
    logic               ss;
    logic               mosi;
    logic               miso;

    modport master (
        input  req, req_data, miso,
        output gnt, done, done_id, rdata, scl, ss, mosi
    );

    modport slave (
        output req, req_data, miso,
        input  gnt, done, done_id, rdata, scl, ss, mosi
    );
endinterface

// File: rtl/spi_rr_arb.sv
// rtl/spi_rr_arb.sv - round-robin picker with pointer advanced only on an accepted grant
module spi_rr_arb
    import spi_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = idx_w(NREQ)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            valid
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cand;

    // Scan requesters starting at the pointer; first active one wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        gnt = valid ? (NREQ'(1) << idx) : '0;
    end

    // Pointer moves to the requester after the one just served.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (en && valid) begin
            ptr <= (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_arb.sv
// rtl/spi_master_arb.sv - arbitrated SPI master; SPI_LSB_FIRST_EN selects LSB-first shifting
module spi_master_arb
    import spi_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DW      = 8,
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = CPOL_IDLE_HIGH,
    parameter bit CPHA    = CPHA_TRAILING
) (
    input  logic clk,
    input  logic rstn,
    spi_master_arb_if.master bus
);

    localparam int IDW = idx_w(NREQ);
    localparam int BCW = bit_cnt_w(DW);
    localparam int DCW = div_cnt_w(CLK_DIV);
    localparam logic [DCW-1:0] DIV_LOAD  = DCW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] LAST_EDGE = BCW'(2 * DW - 1);

`ifdef SPI_LSB_FIRST_EN
    function automatic logic first_bit(input logic [DW-1:0] w);
        return w[0];
    endfunction
    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w);
        return {1'b0, w[DW-1:1]};
    endfunction
    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] w, input logic b);
        return {b, w[DW-1:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [DW-1:0] w);
        return w[DW-1];
    endfunction
    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w);
        return {w[DW-2:0], 1'b0};
    endfunction
    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] w, input logic b);
        return {w[DW-2:0], b};
    endfunction
`endif

    logic [2:0]      state;
    logic [DCW-1:0]  div_cnt;
    logic [BCW-1:0]  edge_cnt;
    logic [DW-1:0]   tx_sreg;
    logic [DW-1:0]   rx_sreg;
    logic [NREQ-1:0] gnt_q;
    logic            done_q;
    logic [IDW-1:0]  done_id_q;
    logic [DW-1:0]   rdata_q;
    logic            scl_q;
    logic            ss_q;
    logic            mosi_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic            arb_valid;
    logic            arb_en;
    logic [DW-1:0]   pick_data;
    logic            edge_tick;
    logic            lead_edge;
    logic            last_edge;
    logic            sample_edge;
    logic            drive_edge;

    // Arbitration is only honoured in IDLE, so GAP requests are ignored.
    assign arb_en    = (state == ST_IDLE);
    assign pick_data = bus.req_data[int'(arb_idx) * DW +: DW];

    spi_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .req   (bus.req),
        .en    (arb_en),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // edge_cnt holds edges already made, so the upcoming edge is odd (leading) when it is even.
    assign edge_tick   = (state == ST_XFER) && (div_cnt == '0);
    assign lead_edge   = ~edge_cnt[0];
    assign last_edge   = (edge_cnt == LAST_EDGE);
    assign sample_edge = edge_tick && ((CPHA == CPHA_TRAILING) ? !lead_edge : lead_edge);
    assign drive_edge  = edge_tick && ((CPHA == CPHA_TRAILING) ? lead_edge
                                                               : (!lead_edge && !last_edge));

    // Transaction sequencer: grant, setup, 2*DW scl edges, hold, deselect gap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            tx_sreg   <= '0;
            rx_sreg   <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            rdata_q   <= '0;
            scl_q     <= CPOL;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    div_cnt  <= DIV_LOAD;
                    edge_cnt <= '0;
                    if (arb_valid) begin
                        gnt_q     <= arb_gnt;
                        done_id_q <= arb_idx;
                        ss_q      <= 1'b0;
                        rx_sreg   <= '0;
                        state     <= ST_SETUP;
                        if (CPHA == CPHA_TRAILING) begin
                            tx_sreg <= pick_data;
                        end else begin
                            mosi_q  <= first_bit(pick_data);
                            tx_sreg <= shift_out(pick_data);
                        end
                    end
                end
                ST_SETUP: begin
                    edge_cnt <= '0;
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_LOAD;
                        state   <= ST_XFER;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_XFER: begin
                    if (edge_tick) begin
                        div_cnt  <= DIV_LOAD;
                        scl_q    <= ~scl_q;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sample_edge) begin
                            rx_sreg <= shift_in(rx_sreg, bus.miso);
                        end
                        if (drive_edge) begin
                            mosi_q  <= first_bit(tx_sreg);
                            tx_sreg <= shift_out(tx_sreg);
                        end
                        if (last_edge) begin
                            edge_cnt <= '0;
                            state    <= ST_HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    edge_cnt <= '0;
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_LOAD;
                        ss_q    <= 1'b1;
                        done_q  <= 1'b1;
                        rdata_q <= rx_sreg;
                        mosi_q  <= 1'b0;
                        state   <= ST_GAP;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    edge_cnt <= '0;
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_LOAD;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: begin
                    div_cnt  <= DIV_LOAD;
                    edge_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.rdata   = rdata_q;
    assign bus.scl     = scl_q;
    assign bus.ss      = ss_q;
    assign bus.mosi    = mosi_q;

endmodule
